// File: rtl/sram_bus_pkg.sv
// sram_bus_pkg: shared constants for the AVR external-SRAM bus mux.
// Contents: FSM state encoding, internal register page offsets and the read
// value returned for unmapped addresses.
package sram_bus_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StAccess = 2'd1;
  localparam state_t StDone   = 2'd2;

  // Offsets within the internal register page
  localparam int unsigned REG_IRQ_PEND = 0;
  localparam int unsigned REG_IRQ_MASK = 1;
  localparam int unsigned REG_STATUS   = 2;

  localparam logic [7:0] UNMAPPED_RDATA = 8'hFF;

endpackage

// File: rtl/sram_bus_irq.sv
// sram_bus_irq: interrupt mask register and registered, level-sensitive
// aggregation of the slave interrupt requests.
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_mask_we        write strobe for the mask register
//   i_mask_wdata     new mask value
//   i_s_irq          per-slave level interrupt requests
//   o_mask           current mask register
//   o_pend           s_irq & mask (combinational, for register reads)
//   o_irq            registered OR of the pending bits
module sram_bus_irq #(
  parameter int unsigned NUM_SLAVES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mask_we,
  input  logic [NUM_SLAVES-1:0] i_mask_wdata,
  input  logic [NUM_SLAVES-1:0] i_s_irq,
  output logic [NUM_SLAVES-1:0] o_mask,
  output logic [NUM_SLAVES-1:0] o_pend,
  output logic                  o_irq
);

  logic [NUM_SLAVES-1:0] r_mask;
  logic                  r_irq;
  logic [NUM_SLAVES-1:0] w_pend;

  assign w_pend = i_s_irq & r_mask;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mask <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (i_mask_we) r_mask <= i_mask_wdata;
      r_irq <= |w_pend;
    end
  end

  assign o_mask = r_mask;
  assign o_pend = w_pend;
  assign o_irq  = r_irq;

endmodule

// File: rtl/sram_bus_mux.sv
// sram_bus_mux: bridge from the AVR external-SRAM bus to NUM_SLAVES
// memory-mapped slaves. Addresses from BASE are split into 2^SPAN_LOG2-byte
// slots; slot NUM_SLAVES is an internal register page, anything else is
// unmapped. Slave accesses are sequenced IDLE -> ACCESS -> DONE with wait-state
// stretching; an optional bus timeout is enabled by the macro
// SRAM_BUS_MUX_TIMEOUT_EN (when undefined ACCESS waits forever, STATUS reads 0).
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_m_a/i_m_d_in          master address / write data
//   o_m_d_out               registered read data to master
//   i_m_cs/i_m_oe/i_m_we    master strobe, read enable, write enable
//   o_m_wait                combinational stall to master
//   o_s_a/o_s_d_out         shared slave offset / write data
//   i_s_d_in                packed slave read data, slave k at [k*DATA_W +: DATA_W]
//   o_s_cs/o_s_oe/o_s_we    one-hot select, read and write strobes
//   i_s_wait/i_s_irq        per-slave wait and level interrupt
//   o_irq                   aggregated masked interrupt
module sram_bus_mux
  import sram_bus_pkg::*;
#(
  parameter int unsigned       NUM_SLAVES = 2,
  parameter int unsigned       ADDR_W     = 16,
  parameter int unsigned       DATA_W     = 8,
  parameter logic [ADDR_W-1:0] BASE       = 16'h8000,
  parameter int unsigned       SPAN_LOG2  = 8,
  parameter int unsigned       TIMEOUT    = 64
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [ADDR_W-1:0]            i_m_a,
  input  logic [DATA_W-1:0]            i_m_d_in,
  output logic [DATA_W-1:0]            o_m_d_out,
  input  logic                         i_m_cs,
  input  logic                         i_m_oe,
  input  logic                         i_m_we,
  output logic                         o_m_wait,
  output logic [SPAN_LOG2-1:0]         o_s_a,
  output logic [DATA_W-1:0]            o_s_d_out,
  input  logic [NUM_SLAVES*DATA_W-1:0] i_s_d_in,
  output logic [NUM_SLAVES-1:0]        o_s_cs,
  output logic                         o_s_oe,
  output logic                         o_s_we,
  input  logic [NUM_SLAVES-1:0]        i_s_wait,
  input  logic [NUM_SLAVES-1:0]        i_s_irq,
  output logic                         o_irq
);

  localparam int unsigned SLOT_W = 3;

  state_t                r_state;
  logic [DATA_W-1:0]     r_m_d_out;
  logic [NUM_SLAVES-1:0] r_s_cs;
  logic [SPAN_LOG2-1:0]  r_s_a;
  logic [DATA_W-1:0]     r_s_d_out;
  logic                  r_s_oe;
  logic                  r_s_we;

  logic [ADDR_W-1:0]     w_off;
  logic [ADDR_W-1:0]     w_slot;
  logic [SLOT_W-1:0]     w_slot_idx;
  logic [SPAN_LOG2-1:0]  w_reg_off;
  logic                  w_req;
  logic                  w_hit_slave;
  logic                  w_hit_int;
  logic                  w_int_wr;
  logic                  w_mask_we;
  logic [NUM_SLAVES-1:0] w_mask;
  logic [NUM_SLAVES-1:0] w_pend;
  logic [DATA_W-1:0]     w_status;
  logic [DATA_W-1:0]     w_int_rdata;
  logic [DATA_W-1:0]     w_s_rdata;
  logic                  w_s_wait;

  // Addresses below BASE wrap to a huge slot number and fall out as unmapped
  assign w_off       = i_m_a - BASE;
  assign w_slot      = w_off >> SPAN_LOG2;
  assign w_slot_idx  = w_slot[SLOT_W-1:0];
  assign w_reg_off   = w_off[SPAN_LOG2-1:0];
  assign w_req       = i_m_cs & (i_m_oe | i_m_we);
  assign w_hit_slave = w_slot < ADDR_W'(NUM_SLAVES);
  assign w_hit_int   = w_slot == ADDR_W'(NUM_SLAVES);
  assign w_int_wr    = (r_state == StIdle) & w_req & w_hit_int & i_m_we;
  assign w_mask_we   = w_int_wr & (w_reg_off == SPAN_LOG2'(REG_IRQ_MASK));

  sram_bus_irq #(
    .NUM_SLAVES (NUM_SLAVES)
  ) u_irq (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_mask_we    (w_mask_we),
    .i_mask_wdata (i_m_d_in[NUM_SLAVES-1:0]),
    .i_s_irq      (i_s_irq),
    .o_mask       (w_mask),
    .o_pend       (w_pend),
    .o_irq        (o_irq)
  );

`ifdef SRAM_BUS_MUX_TIMEOUT_EN
  logic              r_to_flag;
  logic [SLOT_W-1:0] r_to_slot;
  logic [SLOT_W-1:0] r_slot;
  logic [7:0]        r_tmo_cnt;
  logic              w_stat_clr;

  assign w_stat_clr = w_int_wr & (w_reg_off == SPAN_LOG2'(REG_STATUS)) & i_m_d_in[0];

  always_comb begin
    w_status      = '0;
    w_status[0]   = r_to_flag;
    w_status[6:4] = r_to_slot;
  end
`else
  assign w_status = '0;
`endif

  always_comb begin
    w_int_rdata = '0;
    case (w_reg_off)
      SPAN_LOG2'(REG_IRQ_PEND): w_int_rdata = DATA_W'(w_pend);
      SPAN_LOG2'(REG_IRQ_MASK): w_int_rdata = DATA_W'(w_mask);
      SPAN_LOG2'(REG_STATUS):   w_int_rdata = w_status;
      default:                  w_int_rdata = '0;
    endcase
  end

  // r_s_cs is one-hot (or zero), so OR-reduction selects the active slave
  always_comb begin
    w_s_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (r_s_cs[k]) w_s_rdata = w_s_rdata | i_s_d_in[k*DATA_W +: DATA_W];
    end
  end

  assign w_s_wait = |(i_s_wait & r_s_cs);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_m_d_out <= '0;
      r_s_cs    <= '0;
      r_s_a     <= '0;
      r_s_d_out <= '0;
      r_s_oe    <= 1'b0;
      r_s_we    <= 1'b0;
`ifdef SRAM_BUS_MUX_TIMEOUT_EN
      r_to_flag <= 1'b0;
      r_to_slot <= '0;
      r_slot    <= '0;
      r_tmo_cnt <= '0;
`endif
    end else begin
      case (r_state)
        StIdle: begin
          if (w_req) begin
            if (w_hit_slave) begin
              r_state   <= StAccess;
              r_s_cs    <= NUM_SLAVES'(1) << w_slot_idx;
              r_s_a     <= w_reg_off;
              r_s_d_out <= i_m_d_in;
              r_s_we    <= i_m_we;
              r_s_oe    <= ~i_m_we;
`ifdef SRAM_BUS_MUX_TIMEOUT_EN
              r_slot    <= w_slot_idx;
              r_tmo_cnt <= '0;
`endif
            end else begin
              r_state <= StDone;
              if (!i_m_we) r_m_d_out <= w_hit_int ? w_int_rdata : DATA_W'(UNMAPPED_RDATA);
`ifdef SRAM_BUS_MUX_TIMEOUT_EN
              // A timeout can only be set in StAccess, so this clear never races it
              if (w_stat_clr) r_to_flag <= 1'b0;
`endif
            end
          end
        end
        StAccess: begin
          if (!i_m_cs) begin
            // Abort: master gave up, leave read data and status untouched
            r_state <= StIdle;
            r_s_cs  <= '0;
            r_s_oe  <= 1'b0;
            r_s_we  <= 1'b0;
          end else if (!w_s_wait) begin
            r_state <= StDone;
            if (r_s_oe) r_m_d_out <= w_s_rdata;
            r_s_cs  <= '0;
            r_s_oe  <= 1'b0;
            r_s_we  <= 1'b0;
          end
`ifdef SRAM_BUS_MUX_TIMEOUT_EN
          else if (r_tmo_cnt == 8'(TIMEOUT - 1)) begin
            r_state   <= StDone;
            r_m_d_out <= DATA_W'(UNMAPPED_RDATA);
            r_to_flag <= 1'b1;
            r_to_slot <= r_slot;
            r_s_cs    <= '0;
            r_s_oe    <= 1'b0;
            r_s_we    <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
          end
`endif
        end
        StDone: begin
          if (!i_m_cs) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Combinational so the AVR is stalled in the very cycle it makes the request
  assign o_m_wait  = ~i_rst & (((r_state == StIdle) & w_req) | (r_state == StAccess));
  assign o_m_d_out = r_m_d_out;
  assign o_s_cs    = r_s_cs;
  assign o_s_a     = r_s_a;
  assign o_s_d_out = r_s_d_out;
  assign o_s_oe    = r_s_oe;
  assign o_s_we    = r_s_we;

endmodule

// File: tb/tb_sram_bus_mux.sv
module tb_sram_bus_mux;

  logic        clk;
  logic        rst;
  logic [15:0] m_a;
  logic [7:0]  m_d_in;
  logic [7:0]  m_d_out;
  logic        m_cs;
  logic        m_oe;
  logic        m_we;
  logic        m_wait;
  logic [7:0]  s_a;
  logic [7:0]  s_d_out;
  logic [15:0] s_d_in;
  logic [1:0]  s_cs;
  logic        s_oe;
  logic        s_we;
  logic [1:0]  s_wait;
  logic [1:0]  s_irq;
  logic        irq;

  logic [7:0]  slv_rdata [2];
  logic [7:0]  exp_q [$];
  int          checks;
  int          errors;

  assign s_d_in = {slv_rdata[1], slv_rdata[0]};

  sram_bus_mux dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_m_a     (m_a),
    .i_m_d_in  (m_d_in),
    .o_m_d_out (m_d_out),
    .i_m_cs    (m_cs),
    .i_m_oe    (m_oe),
    .i_m_we    (m_we),
    .o_m_wait  (m_wait),
    .o_s_a     (s_a),
    .o_s_d_out (s_d_out),
    .i_s_d_in  (s_d_in),
    .o_s_cs    (s_cs),
    .o_s_oe    (s_oe),
    .o_s_we    (s_we),
    .i_s_wait  (s_wait),
    .i_s_irq   (s_irq),
    .o_irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Complete one master access; lat = cycles until m_wait low (300 = never)
  task automatic bus_access(input logic [15:0] addr, input logic [7:0] wd, input bit we,
                            output logic [7:0] rd, output int lat);
    m_a = addr; m_d_in = wd; m_we = we; m_oe = !we; m_cs = 1'b1;
    lat = 0;
    while (lat < 300) begin
      tick();
      lat++;
      if (!m_wait) break;
    end
    rd = m_d_out;
    m_cs = 1'b0; m_oe = 1'b0; m_we = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; m_a = '0; m_d_in = '0; m_cs = 0; m_oe = 0; m_we = 0;
    s_wait = '0; s_irq = '0; slv_rdata[0] = '0; slv_rdata[1] = '0;
    tick(); tick();
    checks++; if (m_d_out !== 8'h00) begin errors++; $display("FAIL reset_m_d_out got %h want 00", m_d_out); end
    checks++; if (m_wait !== 1'b0) begin errors++; $display("FAIL reset_m_wait got %b want 0", m_wait); end
    checks++; if ({s_cs, s_oe, s_we} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b want 0000", {s_cs, s_oe, s_we}); end
    checks++; if ({s_a, s_d_out} !== 16'h0) begin errors++; $display("FAIL reset_s_bus got %h want 0000", {s_a, s_d_out}); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_zero_wait_read();
    logic [7:0] e;
    slv_rdata[1] = 8'h5A; s_wait = 2'b00;
    exp_q.push_back(8'h5A);
    m_a = 16'h8105; m_oe = 1'b1; m_we = 1'b0; m_cs = 1'b1;
    #1;
    checks++; if (m_wait !== 1'b1) begin errors++; $display("FAIL zw_wait_c0 got %b want 1", m_wait); end
    tick();
    checks++; if (s_cs !== 2'b10) begin errors++; $display("FAIL zw_s_cs got %b want 10", s_cs); end
    checks++; if (s_a !== 8'h05 || s_oe !== 1'b1 || s_we !== 1'b0) begin
      errors++; $display("FAIL zw_s_a_oe got a=%h oe=%b we=%b want a=05 oe=1 we=0", s_a, s_oe, s_we);
    end
    tick();
    e = exp_q.pop_front();
    checks++; if (m_wait !== 1'b0 || m_d_out !== e) begin
      errors++; $display("FAIL zw_done got wait=%b d=%h want wait=0 d=%h", m_wait, m_d_out, e);
    end
    checks++; if (s_cs !== 2'b00) begin errors++; $display("FAIL zw_cs_clear got %b want 00", s_cs); end
    m_cs = 1'b0; m_oe = 1'b0;
    tick();
  endtask

  task automatic test_wait_write();
    int we_cnt;
    int done_at;
    s_wait = 2'b01; we_cnt = 0; done_at = 0;
    m_a = 16'h8010; m_d_in = 8'h3C; m_we = 1'b1; m_oe = 1'b0; m_cs = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (s_we && s_cs == 2'b01 && s_d_out == 8'h3C) we_cnt++;
      if (!m_wait && done_at == 0) done_at = c;
      if (c == 4) s_wait = 2'b00;
    end
    checks++; if (we_cnt != 4) begin errors++; $display("FAIL ww_we_cycles got %0d want 4", we_cnt); end
    checks++; if (done_at != 5) begin errors++; $display("FAIL ww_done_cycle got %0d want 5", done_at); end
    m_cs = 1'b0; m_we = 1'b0;
    tick();
  endtask

  task automatic test_unmapped();
    logic [7:0] rd;
    logic [7:0] e;
    int         lat;
    slv_rdata[0] = 8'h11;
    exp_q.push_back(8'h11);
    bus_access(16'h8000, 8'h00, 1'b0, rd, lat);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL um_pre_read got %h want %h", rd, e); end
    bus_access(16'h9000, 8'h99, 1'b1, rd, lat);
    checks++; if (lat != 1 || rd !== 8'h11) begin
      errors++; $display("FAIL um_write_drop got lat=%0d d=%h want lat=1 d=11", lat, rd);
    end
    exp_q.push_back(8'hFF);
    m_a = 16'h9000; m_oe = 1'b1; m_cs = 1'b1;
    #1;
    checks++; if (s_cs !== 2'b00) begin errors++; $display("FAIL um_cs_c0 got %b want 00", s_cs); end
    tick();
    e = exp_q.pop_front();
    checks++; if (m_wait !== 1'b0 || m_d_out !== e || s_cs !== 2'b00) begin
      errors++; $display("FAIL um_read got wait=%b d=%h cs=%b want wait=0 d=%h cs=00", m_wait, m_d_out, s_cs, e);
    end
    m_cs = 1'b0; m_oe = 1'b0;
    tick();
    exp_q.push_back(8'hFF);
    slv_rdata[0] = 8'h22;
    bus_access(16'h7FFF, 8'h00, 1'b0, rd, lat);
    e = exp_q.pop_front();
    checks++; if (rd !== e || lat != 1) begin
      errors++; $display("FAIL um_below_base got d=%h lat=%0d want d=%h lat=1", rd, lat, e);
    end
  endtask

  task automatic test_irq();
    logic [7:0] rd;
    logic [7:0] e;
    int         lat;
    bus_access(16'h8201, 8'h02, 1'b1, rd, lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL irq_mask_wr_lat got %0d want 1", lat); end
    exp_q.push_back(8'h02);
    bus_access(16'h8201, 8'h00, 1'b0, rd, lat);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL irq_mask_rd got %h want %h", rd, e); end
    s_irq = 2'b01;
    tick(); tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b want 0", irq); end
    s_irq = 2'b10;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_not_comb got %b want 0", irq); end
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_latency got %b want 1", irq); end
    s_irq = 2'b11;
    exp_q.push_back(8'h02);
    bus_access(16'h8200, 8'h00, 1'b0, rd, lat);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL irq_pend got %h want %h", rd, e); end
    bus_access(16'h8201, 8'h00, 1'b1, rd, lat);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_unmask got %b want 0", irq); end
    s_irq = 2'b00;
  endtask

  task automatic test_abort();
    logic [7:0] rd;
    logic [7:0] e;
    int         lat;
    exp_q.push_back(8'hFF);
    bus_access(16'hA000, 8'h00, 1'b0, rd, lat);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL ab_pre got %h want %h", rd, e); end
    slv_rdata[0] = 8'h77; s_wait = 2'b01;
    m_a = 16'h8000; m_oe = 1'b1; m_cs = 1'b1;
    tick(); tick(); tick();
    checks++; if (s_cs !== 2'b01 || m_wait !== 1'b1) begin
      errors++; $display("FAIL ab_stalled got cs=%b wait=%b want cs=01 wait=1", s_cs, m_wait);
    end
    m_cs = 1'b0; m_oe = 1'b0;
    tick();
    checks++; if ({s_cs, s_oe, s_we, m_wait} !== 5'b0 || m_d_out !== 8'hFF) begin
      errors++; $display("FAIL ab_clear got cs=%b oe=%b we=%b wait=%b d=%h want 0 0 0 0 d=ff",
                         s_cs, s_oe, s_we, m_wait, m_d_out);
    end
    s_wait = 2'b00;
    exp_q.push_back(8'h00);
    bus_access(16'h8202, 8'h00, 1'b0, rd, lat);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL ab_status got %h want %h", rd, e); end
  endtask

  task automatic test_long_wait();
    logic [7:0] rd;
    logic [7:0] e;
    int         lat;
    int         cs_cnt;
    s_wait = 2'b10; cs_cnt = 0;
`ifdef SRAM_BUS_MUX_TIMEOUT_EN
    exp_q.push_back(8'hFF);
    m_a = 16'h8100; m_oe = 1'b1; m_cs = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      if (s_cs == 2'b10) cs_cnt++;
      if (!m_wait) break;
    end
    e = exp_q.pop_front();
    checks++; if (cs_cnt != 64) begin errors++; $display("FAIL to_cs_cycles got %0d want 64", cs_cnt); end
    checks++; if (m_wait !== 1'b0 || m_d_out !== e) begin
      errors++; $display("FAIL to_done got wait=%b d=%h want wait=0 d=%h", m_wait, m_d_out, e);
    end
    m_cs = 1'b0; m_oe = 1'b0;
    tick();
    s_wait = 2'b00;
    exp_q.push_back(8'h11);
    bus_access(16'h8202, 8'h00, 1'b0, rd, lat);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL to_status got %h want %h", rd, e); end
    bus_access(16'h8202, 8'h01, 1'b1, rd, lat);
    exp_q.push_back(8'h10);
    bus_access(16'h8202, 8'h00, 1'b0, rd, lat);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL to_status_clr got %h want %h", rd, e); end
`else
    m_a = 16'h8100; m_oe = 1'b1; m_cs = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      if (s_cs == 2'b10) cs_cnt++;
    end
    checks++; if (cs_cnt != 100 || m_wait !== 1'b1) begin
      errors++; $display("FAIL nt_hold got cs_cycles=%0d wait=%b want 100 1", cs_cnt, m_wait);
    end
    m_cs = 1'b0; m_oe = 1'b0;
    tick();
    checks++; if (s_cs !== 2'b00 || m_wait !== 1'b0) begin
      errors++; $display("FAIL nt_abort got cs=%b wait=%b want 00 0", s_cs, m_wait);
    end
    s_wait = 2'b00;
    exp_q.push_back(8'h00);
    bus_access(16'h8202, 8'h00, 1'b0, rd, lat);
    e = exp_q.pop_front();
    checks++; if (rd !== e) begin errors++; $display("FAIL nt_status got %h want %h", rd, e); end
`endif
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] rd;
    logic [7:0] e;
    int         lat;
    s_wait = 2'b01; slv_rdata[0] = 8'hA5;
    m_a = 16'h8000; m_oe = 1'b1; m_we = 1'b0; m_cs = 1'b1;
    tick(); tick();
    checks++; if (s_cs !== 2'b01 || s_oe !== 1'b1) begin
      errors++; $display("FAIL rm_in_access got cs=%b oe=%b want 01 1", s_cs, s_oe);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if ({s_cs, s_oe, s_we, m_wait} !== 5'b0) begin
      errors++; $display("FAIL rm_async_drop got cs=%b oe=%b we=%b wait=%b want all 0", s_cs, s_oe, s_we, m_wait);
    end
    m_cs = 1'b0; m_oe = 1'b0; s_wait = 2'b00;
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(8'hA5);
    bus_access(16'h8000, 8'h00, 1'b0, rd, lat);
    e = exp_q.pop_front();
    checks++; if (rd !== e || lat != 2) begin
      errors++; $display("FAIL rm_after got d=%h lat=%0d want d=%h lat=2", rd, lat, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  rd;
    logic [7:0]  e;
    logic [15:0] addr;
    int          lat;
    int          k;
    for (int i = 0; i < 6; i++) begin
      k = i % 2;
      slv_rdata[k] = 8'($urandom);
      addr = 16'h8000 + 16'(k * 256) + 16'($urandom_range(0, 255));
      exp_q.push_back(slv_rdata[k]);
      bus_access(addr, 8'h00, 1'b0, rd, lat);
      e = exp_q.pop_front();
      checks++; if (rd !== e || lat != 2) begin
        errors++; $display("FAIL b2b_%0d got d=%h lat=%0d want d=%h lat=2", i, rd, lat, e);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_zero_wait_read();
    test_wait_write();
    test_unmapped();
    test_irq();
    test_abort();
    test_long_wait();
    test_reset_mid_access();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
